// File: rtl/complex_mult_pkg.sv
// Shared types and helpers for the complex multiplier engine.
// State encoding and derived-width helpers used by the top and by the bench.
package complex_mult_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULTIPLY = 2'd1,
        COMPUTE  = 2'd2,
        WAIT_RES = 2'd3
    } state_t;

    function automatic int steps_f(input int num_mult);
        return 4 / num_mult;
    endfunction

    function automatic int res_w_f(input int data_w);
        return 2 * data_w + 1;
    endfunction

endpackage

// File: rtl/cm_mult_lane.sv
// One physical signed multiplier lane with a registered full-width product.
// The product register loads only when the engine enables this lane.
module cm_mult_lane #(
    parameter int DATA_W = 16
) (
    input  logic                       clk,
    input  logic                       sw_rst,
    input  logic                       i_load,
    input  logic signed [DATA_W-1:0]   i_a,
    input  logic signed [DATA_W-1:0]   i_b,
    output logic signed [2*DATA_W-1:0] o_prod
);

    logic signed [2*DATA_W-1:0] r_prod;

    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_prod <= '0;
        end else if (i_load) begin
            r_prod <= i_a * i_b;
        end
    end

    assign o_prod = r_prod;

endmodule

// File: rtl/complex_mult_engine.sv
// Complex multiplier A*B or A*conj(B) with valid/ready on both sides.
// NUM_MULT lanes are time-shared over 4/NUM_MULT MULTIPLY steps.
module complex_mult_engine
    import complex_mult_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_MULT = 2,
    parameter int RES_W    = res_w_f(DATA_W)
) (
    input  logic                     clk,
    input  logic                     sw_rst,
    input  logic                     op_val,
    output logic                     op_ready,
    input  logic signed [DATA_W-1:0] op_a_re,
    input  logic signed [DATA_W-1:0] op_a_im,
    input  logic signed [DATA_W-1:0] op_b_re,
    input  logic signed [DATA_W-1:0] op_b_im,
    input  logic                     op_conj,
    output logic                     res_val,
    input  logic                     res_ready,
    output logic signed [RES_W-1:0]  res_re,
    output logic signed [RES_W-1:0]  res_im,
    output logic                     busy
);

    localparam int STEPS     = steps_f(NUM_MULT);
    localparam int PROD_W    = 2 * DATA_W;
    localparam int LAST_BASE = (STEPS - 1) * NUM_MULT;

    if (!(NUM_MULT == 1 || NUM_MULT == 2 || NUM_MULT == 4)) begin : g_bad_num_mult
        $error("complex_mult_engine: NUM_MULT must be 1, 2 or 4");
    end
    if (RES_W != res_w_f(DATA_W)) begin : g_bad_res_w
        $error("complex_mult_engine: RES_W is derived and must equal 2*DATA_W+1");
    end

    state_t                     r_state;
    logic [1:0]                 r_step;
    logic signed [DATA_W-1:0]   r_ar, r_ai, r_br, r_bi;
    logic                       r_conj;
    logic signed [RES_W-1:0]    r_res_re, r_res_im;

    logic                       w_accept;
    logic                       w_mult_en;
    logic signed [PROD_W-1:0]   w_lane_prod [NUM_MULT];
    logic signed [PROD_W-1:0]   w_prod [4];
    logic signed [RES_W-1:0]    w_ext [4];

    assign op_ready  = (r_state == IDLE) | ((r_state == WAIT_RES) & res_ready);
    assign w_accept  = op_val & op_ready;
    assign w_mult_en = (r_state == MULTIPLY);
    assign res_val   = (r_state == WAIT_RES);
    assign busy      = (r_state != IDLE);
    assign res_re    = r_res_re;
    assign res_im    = r_res_im;

    // Stage: lane operand select -> registered partial products (p0..p3 by index)
    for (genvar l = 0; l < NUM_MULT; l++) begin : g_lane
        logic [1:0]               w_idx;
        logic signed [DATA_W-1:0] w_op_a, w_op_b;

        assign w_idx  = 2'((int'(r_step) * NUM_MULT) + l);
        assign w_op_a = (w_idx == 2'd0 || w_idx == 2'd2) ? r_ar : r_ai;
        assign w_op_b = (w_idx == 2'd0 || w_idx == 2'd3) ? r_br : r_bi;

        cm_mult_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk    (clk),
            .sw_rst (sw_rst),
            .i_load (w_mult_en),
            .i_a    (w_op_a),
            .i_b    (w_op_b),
            .o_prod (w_lane_prod[l])
        );
    end

    // Lanes are reused across steps, so earlier-step products are parked here
    if (STEPS > 1) begin : g_stash
        logic signed [PROD_W-1:0] r_stash [LAST_BASE];

        always_ff @(posedge clk) begin
            if (sw_rst) begin
                for (int i = 0; i < LAST_BASE; i++) r_stash[i] <= '0;
            end else if (w_mult_en && r_step != 2'd0) begin
                for (int l = 0; l < NUM_MULT; l++)
                    r_stash[(int'(r_step) - 1) * NUM_MULT + l] <= w_lane_prod[l];
            end
        end

        for (genvar k = 0; k < LAST_BASE; k++) begin : g_from_stash
            assign w_prod[k] = r_stash[k];
        end
    end

    for (genvar k = LAST_BASE; k < 4; k++) begin : g_from_lane
        assign w_prod[k] = w_prod_lane_sel(k);
    end

    function automatic logic signed [PROD_W-1:0] w_prod_lane_sel(input int k);
        return w_lane_prod[k - LAST_BASE];
    endfunction

    always_comb begin
        for (int k = 0; k < 4; k++)
            w_ext[k] = {{(RES_W - PROD_W){w_prod[k][PROD_W-1]}}, w_prod[k]};
    end

    // Stage: FSM, operand capture and final add/sub into result registers
    always_ff @(posedge clk) begin
        if (sw_rst) begin
            r_state  <= IDLE;
            r_step   <= 2'd0;
            r_ar     <= '0;
            r_ai     <= '0;
            r_br     <= '0;
            r_bi     <= '0;
            r_conj   <= 1'b0;
            r_res_re <= '0;
            r_res_im <= '0;
        end else begin
            if (w_accept) begin
                r_ar   <= op_a_re;
                r_ai   <= op_a_im;
                r_br   <= op_b_re;
                r_bi   <= op_b_im;
                r_conj <= op_conj;
                r_step <= 2'd0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= MULTIPLY;
                end
                MULTIPLY: begin
                    if (r_step == 2'(STEPS - 1)) r_state <= COMPUTE;
                    else                         r_step  <= r_step + 2'd1;
                end
                COMPUTE: begin
                    if (r_conj) begin
                        r_res_re <= w_ext[0] + w_ext[1];
                        r_res_im <= w_ext[3] - w_ext[2];
                    end else begin
                        r_res_re <= w_ext[0] - w_ext[1];
                        r_res_im <= w_ext[2] + w_ext[3];
                    end
                    r_state <= WAIT_RES;
                end
                WAIT_RES: begin
                    if (res_ready) r_state <= op_val ? MULTIPLY : IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_mult_engine.sv
// Directed bench: three engines (NUM_MULT = 1, 2, 4) share one stimulus stream
// and are checked against hand-computed results and per-lane-count latencies.
module tb_complex_mult_engine;

    localparam int DW = 8;
    localparam int RW = 2 * DW + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 sw_rst, op_val, op_conj, res_ready;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;

    logic                 op_ready [3];
    logic                 res_val  [3];
    logic                 busy     [3];
    logic signed [RW-1:0] res_re   [3];
    logic signed [RW-1:0] res_im   [3];

    int n_checks = 0;
    int n_fail   = 0;

    complex_mult_engine #(.DATA_W(DW), .NUM_MULT(1)) u_m1 (
        .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_ready(op_ready[0]),
        .op_a_re(a_re), .op_a_im(a_im), .op_b_re(b_re), .op_b_im(b_im),
        .op_conj(op_conj), .res_val(res_val[0]), .res_ready(res_ready),
        .res_re(res_re[0]), .res_im(res_im[0]), .busy(busy[0])
    );

    complex_mult_engine #(.DATA_W(DW), .NUM_MULT(2)) u_m2 (
        .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_ready(op_ready[1]),
        .op_a_re(a_re), .op_a_im(a_im), .op_b_re(b_re), .op_b_im(b_im),
        .op_conj(op_conj), .res_val(res_val[1]), .res_ready(res_ready),
        .res_re(res_re[1]), .res_im(res_im[1]), .busy(busy[1])
    );

    complex_mult_engine #(.DATA_W(DW), .NUM_MULT(4)) u_m4 (
        .clk(clk), .sw_rst(sw_rst), .op_val(op_val), .op_ready(op_ready[2]),
        .op_a_re(a_re), .op_a_im(a_im), .op_b_re(b_re), .op_b_im(b_im),
        .op_conj(op_conj), .res_val(res_val[2]), .res_ready(res_ready),
        .res_re(res_re[2]), .res_im(res_im[2]), .busy(busy[2])
    );

    // Cycles from acceptance to res_val: STEPS+2 for NUM_MULT = 1, 2, 4
    function automatic int per_f(input int d);
        return (d == 0) ? 6 : (d == 1) ? 4 : 3;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int ar, input int ai, input int br, input int bi,
                           input logic conj);
        a_re    = DW'(ar);
        a_im    = DW'(ai);
        b_re    = DW'(br);
        b_im    = DW'(bi);
        op_conj = conj;
    endtask

    task automatic check_idle(input string tag, input int d);
        check($sformatf("%s_m%0d_ready", tag, d), op_ready[d], 1);
        check($sformatf("%s_m%0d_val", tag, d), res_val[d], 0);
        check($sformatf("%s_m%0d_busy", tag, d), busy[d], 0);
    endtask

    // Single transaction with res_ready held high; called at a negedge with all DUTs idle
    task automatic run_txn(input string tag, input int ar, input int ai, input int br,
                           input int bi, input logic conj, input int exp_re, input int exp_im);
        set_ops(ar, ai, br, bi, conj);
        op_val    = 1'b1;
        res_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            op_val = 1'b0;
            for (int d = 0; d < 3; d++) begin
                check($sformatf("%s_m%0d_val_c%0d", tag, d, k), res_val[d], (k == per_f(d)));
                if (k == per_f(d)) begin
                    check($sformatf("%s_m%0d_re", tag, d), res_re[d], exp_re);
                    check($sformatf("%s_m%0d_im", tag, d), res_im[d], exp_im);
                end
            end
        end
        for (int d = 0; d < 3; d++) check_idle($sformatf("%s_end", tag), d);
    endtask

    initial begin
        sw_rst    = 1'b1;
        op_val    = 1'b1;
        res_ready = 1'b0;
        set_ops(3, 4, 5, -2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_idle("rst", d);
            check($sformatf("rst_m%0d_re", d), res_re[d], 0);
            check($sformatf("rst_m%0d_im", d), res_im[d], 0);
        end
        sw_rst = 1'b0;
        op_val = 1'b0;
        @(negedge clk);

        run_txn("basic",  3, 4, 5, -2, 1'b0, 23, 14);
        run_txn("conj",   3, 4, 5, -2, 1'b1, 7, 26);
        run_txn("min",    -128, -128, -128, -128, 1'b0, 0, 32768);
        run_txn("minc",   -128, -128, -128, -128, 1'b1, 32768, 0);
        run_txn("edge",   127, -128, -128, 127, 1'b0, 0, 32513);
        run_txn("edgec",  127, -128, -128, 127, 1'b1, -32512, 255);
        run_txn("negj",   -1, 0, 0, -1, 1'b0, 0, 1);

        // Consumer stall: result must hold and no new operands accepted
        set_ops(3, 4, 5, -2, 1'b0);
        op_val    = 1'b1;
        res_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            op_val = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            for (int d = 0; d < 3; d++) begin
                check($sformatf("hold_m%0d_val_c%0d", d, k), res_val[d], 1);
                check($sformatf("hold_m%0d_re_c%0d", d, k), res_re[d], 23);
                check($sformatf("hold_m%0d_im_c%0d", d, k), res_im[d], 14);
                check($sformatf("hold_m%0d_ready_c%0d", d, k), op_ready[d], 0);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) check($sformatf("hold_m%0d_ready_comb", d), op_ready[d], 1);
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle("release", d);

        // Back-to-back: new operands taken on the same edge the result is consumed
        set_ops(3, 4, 5, -2, 1'b0);
        op_val    = 1'b1;
        res_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) set_ops(127, -128, -128, 127, 1'b1);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("b2b_m%0d_val_c%0d", d, k), res_val[d], (k % per_f(d) == 0));
                check($sformatf("b2b_m%0d_busy_c%0d", d, k), busy[d], 1);
                check($sformatf("b2b_m%0d_ready_c%0d", d, k), op_ready[d], (k % per_f(d) == 0));
                if (k % per_f(d) == 0) begin
                    check($sformatf("b2b_m%0d_re_c%0d", d, k), res_re[d],
                          (k == per_f(d)) ? 23 : -32512);
                    check($sformatf("b2b_m%0d_im_c%0d", d, k), res_im[d],
                          (k == per_f(d)) ? 14 : 255);
                end
            end
            if (k == 12) op_val = 1'b0;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) check_idle("b2b_end", d);

        // Reset during MULTIPLY step 1 aborts the transaction and clears results
        set_ops(3, 4, 5, -2, 1'b0);
        op_val = 1'b1;
        @(negedge clk);
        op_val = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("abort_m%0d_busy", d), busy[d], 1);
            check($sformatf("abort_m%0d_val", d), res_val[d], 0);
        end
        sw_rst = 1'b1;
        op_val = 1'b1;
        @(negedge clk);
        sw_rst = 1'b0;
        op_val = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_idle("abort", d);
            check($sformatf("abort_m%0d_re", d), res_re[d], 0);
            check($sformatf("abort_m%0d_im", d), res_im[d], 0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("abort_m%0d_noval_c%0d", d, k), res_val[d], 0);
                check($sformatf("abort_m%0d_nobusy_c%0d", d, k), busy[d], 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
